// File: rtl/evt_stream_arbiter_if.sv
// evt_stream_arbiter_if -- bundle of N first-word-fall-through event streams.
//
// Each lane k carries a 32-bit word in data[32k+31:32k], an empty flag and an
// evtdone (last word of event) flag. The consumer pops lane k with re[k].
//
// Handshake: a lane holds a valid word whenever empty[k]=0; the word and
// evtdone[k] stay stable until the consumer raises re[k] in a cycle where
// empty[k]=0, which retires that word at the rising clock edge. A re[k] seen
// while empty[k]=1 has no effect.
//
// Modports:
//   master : the producer (drives empty/data/evtdone, observes re)
//   slave  : the consumer (observes empty/data/evtdone, drives re)
interface evt_stream_arbiter_if #(
  parameter int N = 1
);
  logic [N-1:0]    empty;
  logic [32*N-1:0] data;
  logic [N-1:0]    evtdone;
  logic [N-1:0]    re;

  modport master (output empty, output data, output evtdone, input re);
  modport slave  (input empty, input data, input evtdone, output re);
endinterface

// File: rtl/evt_stream_arbiter.sv
// evt_stream_arbiter -- event-atomic round-robin merge of N event-builder
// streams into one output stream, with a stall watchdog and a register bus.
//
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   reg_we_i       register write strobe
//   reg_addr_i     register address (8 bits)
//   reg_data_i     register write data (16 bits)
//   reg_data_o     register read data, combinational on reg_addr_i
//   src_if         N input streams (slave side): empty/data/evtdone in, re out
//   out_if         single output stream (master side): empty/data/evtdone out,
//                  re in
//   dbg_state_o    current FSM state (IDLE=0, GRANT=1, STREAM=2, TRUNC=3)
//
// Register map: 0x00 STATUS, 0x01 CTRL (enable mask), 0x02 CMD (write
// 0x0000 = soft reset keeping CTRL, 0x0002 = clear EVCNT/TRUNC; reads return
// STATUS), 0x04/0x05 EVCNT low/high, anything else reads 0xF001.
//
// Optional feature macro ARB_SRCID_EN: when defined, bits [7:0] of the first
// word of each forwarded event are replaced by the granted source index.
module evt_stream_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 reg_we_i,
  input  logic [7:0]           reg_addr_i,
  input  logic [15:0]          reg_data_i,
  output logic [15:0]          reg_data_o,
  evt_stream_arbiter_if.slave  src_if,
  evt_stream_arbiter_if.master out_if,
  output logic [1:0]           dbg_state_o
);

`ifdef ARB_SRCID_EN
  localparam bit SrcIdEn = 1'b1;
`else
  localparam bit SrcIdEn = 1'b0;
`endif

  localparam logic [TW-1:0] WdLast    = TW'(TIMEOUT - 1);
  localparam logic [31:0]   TruncWord = 32'hBBBBBBBF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_STREAM = 2'd2,
    S_TRUNC  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    rr_q, rr_d;
  logic [N-1:0]  ctrl_q, ctrl_d;
  logic [N-1:0]  trunc_q, trunc_d;
  logic [31:0]   evcnt_q, evcnt_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          first_q, first_d;
  logic          ov_q, ov_d;
  logic          oe_q, oe_d;
  logic [31:0]   od_q, od_d;

  logic          g_empty, g_evt, found, can_load, trunc_fire;
  logic [31:0]   g_data, load_word;
  logic [N-1:0]  gmask, re_vec;
  logic [2:0]    sel, rr_nxt;
  logic [3:0]    idx;
  logic [15:0]   cand_ext;
  logic          ctrl_wr, cmd_rst, cmd_clr;

  // Output register may take a new word when empty or being popped this cycle.
  assign can_load = !ov_q || out_if.re[0];
  assign rr_nxt   = (grant_q == 3'(N - 1)) ? 3'd0 : grant_q + 3'd1;
  assign ctrl_wr  = reg_we_i && (reg_addr_i == 8'h01);
  assign cmd_rst  = reg_we_i && (reg_addr_i == 8'h02) && (reg_data_i == 16'h0000);
  assign cmd_clr  = reg_we_i && (reg_addr_i == 8'h02) && (reg_data_i == 16'h0002);

  // Granted-lane view of the inputs.
  always_comb begin
    g_empty = 1'b1;
    g_data  = 32'h0;
    g_evt   = 1'b0;
    gmask   = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_q == 3'(k)) begin
        g_empty  = src_if.empty[k];
        g_data   = src_if.data[32*k +: 32];
        g_evt    = src_if.evtdone[k];
        gmask[k] = 1'b1;
      end
    end
  end

  // First enabled, non-empty source at or after the rr pointer, wrapping.
  // The 4-bit index covers rr+i up to 2N-2 before the modulo fold.
  always_comb begin
    found    = 1'b0;
    sel      = 3'd0;
    idx      = 4'd0;
    cand_ext = 16'(ctrl_q & ~src_if.empty);
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, rr_q} + 4'(i);
      if (idx >= 4'(N)) idx = idx - 4'(N);
      if (!found && cand_ext[idx]) begin
        found = 1'b1;
        sel   = idx[2:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    ctrl_d     = ctrl_q;
    trunc_d    = trunc_q;
    evcnt_d    = evcnt_q;
    wd_d       = wd_q;
    first_d    = first_q;
    ov_d       = ov_q & ~out_if.re[0];
    oe_d       = oe_q;
    od_d       = od_q;
    re_vec     = '0;
    trunc_fire = 1'b0;
    load_word  = g_data;
    if (SrcIdEn && first_q) load_word[7:0] = 8'(grant_q);

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = sel;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        wd_d    = '0;
        first_d = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (!g_empty) begin
          // Output stall: no pop, watchdog holds.
          if (can_load) begin
            re_vec  = gmask;
            ov_d    = 1'b1;
            oe_d    = g_evt;
            od_d    = load_word;
            wd_d    = '0;
            first_d = 1'b0;
            if (g_evt) begin
              evcnt_d = evcnt_q + 32'd1;
              rr_d    = rr_nxt;
              state_d = S_IDLE;
            end
          end
        end else begin
          wd_d = wd_q + TW'(1);
          if (wd_q == WdLast) state_d = S_TRUNC;
        end
      end
      S_TRUNC: begin
        if (can_load) begin
          ov_d       = 1'b1;
          oe_d       = 1'b1;
          od_d       = TruncWord;
          trunc_fire = 1'b1;
          trunc_d    = trunc_q | gmask;
          ctrl_d     = ctrl_q & ~gmask;
          rr_d       = rr_nxt;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Quarantine of the truncated source beats a simultaneous CTRL write.
    if (ctrl_wr) ctrl_d = reg_data_i[N-1:0] & ~(trunc_fire ? gmask : '0);
    // Commands override any same-cycle counter or flag update.
    if (cmd_clr) begin
      evcnt_d = '0;
      trunc_d = '0;
    end
    if (cmd_rst) begin
      state_d = S_IDLE;
      grant_d = 3'd0;
      rr_d    = 3'd0;
      trunc_d = '0;
      evcnt_d = '0;
      wd_d    = '0;
      first_d = 1'b0;
      ov_d    = 1'b0;
      oe_d    = 1'b0;
      od_d    = 32'h0;
      re_vec  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      grant_q <= 3'd0;
      rr_q    <= 3'd0;
      ctrl_q  <= '1;
      trunc_q <= '0;
      evcnt_q <= '0;
      wd_q    <= '0;
      first_q <= 1'b0;
      ov_q    <= 1'b0;
      oe_q    <= 1'b0;
      od_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      ctrl_q  <= ctrl_d;
      trunc_q <= trunc_d;
      evcnt_q <= evcnt_d;
      wd_q    <= wd_d;
      first_q <= first_d;
      ov_q    <= ov_d;
      oe_q    <= oe_d;
      od_q    <= od_d;
    end
  end

  assign src_if.re      = re_vec;
  assign out_if.empty   = !ov_q;
  assign out_if.data    = od_q;
  assign out_if.evtdone = oe_q & ov_q;
  assign dbg_state_o    = state_q;

  always_comb begin
    case (reg_addr_i)
      8'h00, 8'h02: reg_data_o = {state_q, grant_q, ov_q, 2'b00, 8'(trunc_q)};
      8'h01:        reg_data_o = 16'(ctrl_q);
      8'h04:        reg_data_o = evcnt_q[15:0];
      8'h05:        reg_data_o = evcnt_q[31:16];
      default:      reg_data_o = 16'hF001;
    endcase
  end

endmodule

// File: tb/tb_evt_stream_arbiter.sv
module tb_evt_stream_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 1024;
  localparam int TW      = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn_i;
  always #5 clk = ~clk;

  logic        reg_we_i;
  logic [7:0]  reg_addr_i;
  logic [15:0] reg_data_i;
  logic [15:0] reg_data_o;
  logic [1:0]  dbg_state;

  evt_stream_arbiter_if #(.N(N)) src_if ();
  evt_stream_arbiter_if #(.N(1)) out_if ();

  evt_stream_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .reg_we_i   (reg_we_i),
    .reg_addr_i (reg_addr_i),
    .reg_data_i (reg_data_i),
    .reg_data_o (reg_data_o),
    .src_if     (src_if),
    .out_if     (out_if),
    .dbg_state_o(dbg_state)
  );

  // ---------------- bench state ----------------
  logic [32:0] srcq [N][$];   // words still held by each source FIFO
  logic [32:0] mq   [N][$];   // model copy of events not yet arbitrated
  logic [32:0] exp_q[$];      // scoreboard: expected {evtdone, data} order
  int          pop_cnt [N];
  longint      pop_t [N];
  longint      trunc_t;
  int          re_mode;       // 0: re_i=1, 1: random, 2: re_i=0
  bit          mon_off;
  int          n_checks, n_pass, n_fail;
  int          m_rr, m_grant, m_evcnt;
  logic [N-1:0] m_ctrl, m_trunc;
  logic [N-1:0] popm;
  logic [32:0] mon_got, mon_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_src();
    for (int k = 0; k < N; k++) begin
      if (srcq[k].size() > 0) begin
        src_if.empty[k]         = 1'b0;
        src_if.data[32*k +: 32] = srcq[k][0][31:0];
        src_if.evtdone[k]       = srcq[k][0][32];
      end else begin
        src_if.empty[k]         = 1'b1;
        src_if.data[32*k +: 32] = 32'h0;
        src_if.evtdone[k]       = 1'b0;
      end
    end
  endtask

  // FWFT sources: pops sampled at the edge, applied on the falling edge.
  always begin
    @(posedge clk);
    popm = src_if.re;
    for (int k = 0; k < N; k++) if (popm[k]) pop_t[k] = $time;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (popm[k] && srcq[k].size() > 0) begin
        void'(srcq[k].pop_front());
        pop_cnt[k]++;
      end
    end
    drive_src();
  end

  always @(negedge clk) begin
    case (re_mode)
      0:       out_if.re = 1'b1;
      1:       out_if.re = ($urandom_range(0, 3) != 0);
      default: out_if.re = 1'b0;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    if (rstn_i === 1'b1 && !mon_off) begin
      if (src_if.re != '0) check("re_onehot", 64'($countones(src_if.re)), 64'd1);
      if (out_if.re[0] === 1'b1 && out_if.empty[0] === 1'b0) begin
        mon_got = {out_if.evtdone[0], out_if.data};
        if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
        else mon_exp = 'x;
        check("out_word", 64'(mon_got), 64'(mon_exp));
        if (mon_got == {1'b1, 32'hBBBBBBBF}) trunc_t = $time;
      end
    end
  end

  // ---------------- reference model ----------------
  // Event-atomic round robin over events already sitting in the sources.
  task automatic predict();
    int sel;
    bit any, first;
    logic [32:0] w;
    while (1) begin
      any = 0;
      sel = 0;
      for (int i = 0; i < N; i++) begin
        int k = (m_rr + i) % N;
        if (!any && m_ctrl[k] && mq[k].size() > 0) begin
          any = 1;
          sel = k;
        end
      end
      if (!any) break;
      first = 1;
      do begin
        w = mq[sel].pop_front();
`ifdef ARB_SRCID_EN
        if (first) w[7:0] = 8'(sel);
`endif
        exp_q.push_back(w);
        first = 0;
      end while (!w[32]);
      m_evcnt++;
      m_grant = sel;
      m_rr    = (sel + 1) % N;
    end
  endtask

  task automatic add_event(input int k, input int len, input logic [31:0] hdr, input bit fixed_hdr);
    logic [32:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), $urandom()};
      if (i == 0 && fixed_hdr) w[31:0] = hdr;
      srcq[k].push_back(w);
      mq[k].push_back(w);
    end
  endtask

  function automatic logic [15:0] exp_status();
    return {2'b00, 3'(m_grant), 1'b0, 2'b00, 8'(m_trunc)};
  endfunction

  task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    reg_we_i = 1'b1; reg_addr_i = a; reg_data_i = d;
    @(negedge clk);
    reg_we_i = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [7:0] a, input logic [15:0] e);
    @(negedge clk);
    reg_addr_i = a;
    #1;
    check(tag, 64'(reg_data_o), 64'(e));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || out_if.empty[0] === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] t1w [7];
  int base, base1, nev, n;
  longint d;
  logic [32:0] first_exp;
  logic [32:0] tw;

  initial begin
    t1w = '{32'hAAAAAAAA, 32'h1, 32'h10, 32'h0, 32'hA0BCC012, 32'h12B0FFFF, 32'hBBBBBBBB};
    rstn_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = 8'h0; reg_data_i = 16'h0;
    re_mode = 0; mon_off = 0; trunc_t = 0;
    n_checks = 0; n_pass = 0; n_fail = 0;
    m_rr = 0; m_grant = 0; m_evcnt = 0; m_ctrl = '1; m_trunc = '0;
    for (int k = 0; k < N; k++) begin pop_cnt[k] = 0; pop_t[k] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_empty", 64'(out_if.empty), 64'd1);
    check("rst_re", 64'(src_if.re), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rstn_i = 1'b1;
    reg_chk("rst_status", 8'h00, exp_status());
    reg_chk("rst_ctrl", 8'h01, 16'h000F);
    reg_chk("rst_evcnt0", 8'h04, 16'h0000);
    reg_chk("bad_addr", 8'h03, 16'hF001);
    reg_chk("cmd_read", 8'h02, exp_status());

    // Single 7-word event from source 0
    @(negedge clk);
    base = pop_cnt[0];
    for (int i = 0; i < 7; i++) begin
      tw = {(i == 6), t1w[i]};
      srcq[0].push_back(tw);
      mq[0].push_back(tw);
    end
    predict();
    wait_drain("t1", 200);
    check("t1_pops", 64'(pop_cnt[0] - base), 64'd7);
    reg_chk("t1_evcnt0", 8'h04, 16'(m_evcnt));
    reg_chk("t1_status", 8'h00, exp_status());

    // Soft reset, then contention 0+2, then all four
    reg_wr(8'h02, 16'h0000);
    m_rr = 0; m_grant = 0; m_evcnt = 0; m_trunc = '0;
    reg_chk("rst_cmd_status", 8'h00, exp_status());
    reg_chk("rst_cmd_ctrl", 8'h01, 16'h000F);
    reg_chk("rst_cmd_evcnt", 8'h04, 16'h0000);
    @(negedge clk);
    add_event(0, 7, 32'h0, 0);
    add_event(2, 7, 32'h0, 0);
    predict();
    wait_drain("t2a", 300);
    @(negedge clk);
    for (int k = 0; k < N; k++) add_event(k, 7, 32'h0, 0);
    predict();
    wait_drain("t2b", 400);
    reg_chk("t2_evcnt0", 8'h04, 16'(m_evcnt));

    // Output back-pressure mid-event
    re_mode = 2;
    repeat (2) @(negedge clk);
    base = pop_cnt[1];
    add_event(1, 5, 32'h0, 0);
    predict();
    first_exp = exp_q[0];
    n = 0;
    while (out_if.empty[0] === 1'b1 && n < 30) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    #1;
    check("bp_valid", 64'(out_if.empty), 64'd0);
    check("bp_data", 64'(out_if.data), 64'(first_exp[31:0]));
    check("bp_pops", 64'(pop_cnt[1] - base), 64'd1);
    re_mode = 0;
    wait_drain("bp", 100);

    // Randomised rounds with random downstream pops
    re_mode = 1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        nev = $urandom_range(0, 2);
        for (int e = 0; e < nev; e++) add_event(k, $urandom_range(1, 6), 32'h0, 0);
      end
      add_event($urandom_range(0, N - 1), $urandom_range(1, 6), 32'h0, 0);
      predict();
      wait_drain("rnd", 2000);
      reg_chk("rnd_evcnt0", 8'h04, 16'(m_evcnt));
      reg_chk("rnd_evcnt1", 8'h05, 16'(m_evcnt >>> 16));
      reg_chk("rnd_status", 8'h00, exp_status());
    end

    // Stall watchdog: source 1 stops after 3 words
    re_mode = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tw = {1'b0, $urandom()};
      srcq[1].push_back(tw);
`ifdef ARB_SRCID_EN
      if (i == 0) tw[7:0] = 8'd1;
`endif
      exp_q.push_back(tw);
    end
    exp_q.push_back({1'b1, 32'hBBBBBBBF});
    m_grant = 1; m_rr = 2; m_ctrl[1] = 1'b0; m_trunc[1] = 1'b1;
    trunc_t = 0;
    wait_drain("trunc", 1300);
    d = (trunc_t - pop_t[1]) / 10;
    check("trunc_delay", 64'(d >= TIMEOUT && d <= TIMEOUT + 4), 64'd1);
    reg_chk("trunc_ctrl", 8'h01, 16'h000D);
    reg_chk("trunc_status", 8'h00, exp_status());
    @(negedge clk);
    base1 = pop_cnt[1];
    add_event(1, 4, 32'h0, 0);
    add_event(0, 3, 32'h0, 0);
    predict();
    wait_drain("quar", 300);
    repeat (10) @(negedge clk);
    check("quar_pops", 64'(pop_cnt[1] - base1), 64'd0);
    reg_chk("quar_status", 8'h00, exp_status());

    // CLR and CTRL read/write
    reg_wr(8'h02, 16'h0002);
    m_evcnt = 0; m_trunc = '0;
    reg_chk("clr_evcnt0", 8'h04, 16'h0000);
    reg_chk("clr_status", 8'h00, exp_status());
    reg_chk("clr_ctrl", 8'h01, 16'h000D);
    reg_wr(8'h01, 16'h0005);
    reg_chk("ctrl_wr", 8'h01, 16'h0005);
    reg_wr(8'h01, 16'h000D);

    // Asynchronous reset mid-stream
    @(negedge clk);
    for (int i = 0; i < 20; i++) srcq[2].push_back({(i == 19), $urandom()});
    mon_off = 1;
    base = pop_cnt[2];
    n = 0;
    while (pop_cnt[2] - base < 5 && n < 100) begin @(negedge clk); n++; end
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_empty", 64'(out_if.empty), 64'd1);
    check("arst_re", 64'(src_if.re), 64'd0);
    for (int k = 0; k < N; k++) begin srcq[k].delete(); mq[k].delete(); end
    exp_q.delete();
    m_rr = 0; m_grant = 0; m_evcnt = 0; m_ctrl = '1; m_trunc = '0;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    mon_off = 0;
    reg_chk("arst_evcnt0", 8'h04, 16'h0000);
    reg_chk("arst_evcnt1", 8'h05, 16'h0000);
    reg_chk("arst_status", 8'h00, exp_status());
    reg_chk("arst_ctrl", 8'h01, 16'h000F);
    @(negedge clk);
    add_event(3, 4, 32'h0, 0);
    add_event(1, 3, 32'h0, 0);
    add_event(0, 5, 32'h0, 0);
    predict();
    wait_drain("post_rst", 300);
    reg_chk("post_rst_status", 8'h00, exp_status());

    // Header tagging path (bit-exact unless ARB_SRCID_EN)
    @(negedge clk);
    add_event(3, 5, 32'hAAAAAAAA, 1);
    predict();
    wait_drain("srcid", 200);
    reg_chk("final_evcnt0", 8'h04, 16'(m_evcnt));

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end
endmodule
